// File: rtl/subpel_row_filter_pkg.sv
// Shared types and constants for the sub-pixel row interpolator.
package interp_pkg;

  typedef enum logic [1:0] {IDLE, FILL, STREAM, FLUSH} state_e;

  localparam int unsigned TAPS = 8;

  // Tap weights for w[0..7]; each set sums to 64.
  localparam int COEF_A [TAPS] = '{-1, 4, -10, 58, 17, -5, 1, 0};
  localparam int COEF_B [TAPS] = '{-1, 4, -11, 40, 40, -11, 4, -1};
  localparam int COEF_C [TAPS] = '{0, 1, -5, 17, 58, -10, 4, -1};

  localparam int ROUND = 32;
  localparam int SHIFT = 6;

  localparam int unsigned S_W    = 3;
  localparam int unsigned S_OUT  = 3;  // shift count from which shifts emit results
  localparam int unsigned S_MAX  = 4;
  localparam int unsigned F_W    = 2;
  localparam int unsigned F_LAST = 3;

endpackage

// File: rtl/subpel_row_filter_if.sv
// Pixel-in / sub-pixel-out stream bundle; slave is the filter, master is the source/sink.
interface subpel_row_filter_if #(parameter int unsigned PIX_W = 8);
  logic             approx_en;
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_pix;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] out_a;
  logic [PIX_W-1:0] out_b;
  logic [PIX_W-1:0] out_c;
  logic             out_last;

  modport slave (
    input  approx_en, in_valid, in_pix, in_last, out_ready,
    output in_ready, out_valid, out_a, out_b, out_c, out_last
  );

  modport master (
    output approx_en, in_valid, in_pix, in_last, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_c, out_last
  );
endinterface

// File: rtl/subpel_row_filter_taps.sv
// Combinational 8-tap quarter/half/three-quarter filters with rounding and clipping.
module subpel_taps
  import interp_pkg::*;
#(
  parameter int unsigned PIX_W = 8
) (
  input  logic [TAPS-1:0][PIX_W-1:0] win,
  output logic [PIX_W-1:0]           a_c,
  output logic [PIX_W-1:0]           b_c,
  output logic [PIX_W-1:0]           c_c
);

  localparam int unsigned ACC_W = PIX_W + 8;
  localparam int          MAXV  = (2 ** PIX_W) - 1;

  logic signed [ACC_W-1:0] acc_a, acc_b, acc_c;

  function automatic logic [PIX_W-1:0] round_clip(input logic signed [ACC_W-1:0] s);
    logic signed [ACC_W-1:0] r;
    r = (s + ACC_W'(ROUND)) >>> SHIFT;
    if (r[ACC_W-1])                  return '0;
    else if (r > ACC_W'(MAXV))       return '1;
    else                             return r[PIX_W-1:0];
  endfunction

  always_comb begin
    acc_a = '0;
    acc_b = '0;
    acc_c = '0;
    for (int i = 0; i < int'(TAPS); i++) begin
      acc_a = acc_a + ACC_W'(COEF_A[i]) * $signed(ACC_W'(win[i]));
      acc_b = acc_b + ACC_W'(COEF_B[i]) * $signed(ACC_W'(win[i]));
      acc_c = acc_c + ACC_W'(COEF_C[i]) * $signed(ACC_W'(win[i]));
    end
  end

  assign a_c = round_clip(acc_a);
  assign b_c = round_clip(acc_b);
  assign c_c = round_clip(acc_c);

endmodule

// File: rtl/subpel_row_filter.sv
// Streaming 1-D luma sub-pixel interpolator: edge-replicating window, FSM, output register.
module subpel_row_filter
  import interp_pkg::*;
#(
  parameter int unsigned PIX_W      = 8,
  parameter int unsigned APPROX_LSB = 2
) (
  input  logic                clock,
  input  logic                reset_n,
  subpel_row_filter_if.slave  bus,
  output logic                busy
);

  localparam logic [PIX_W-1:0] LSB_MASK = PIX_W'((2 ** APPROX_LSB) - 1);

  state_e                       state_q, state_d;
  logic [TAPS-1:0][PIX_W-1:0]   win_q, win_d;
  logic [S_W-1:0]               s_q, s_d;
  logic [F_W-1:0]               f_q, f_d;
  logic                         approx_q, approx_d;
  logic                         out_valid_q, out_valid_d;
  logic                         out_last_q, out_last_d;
  logic [PIX_W-1:0]             out_a_q, out_a_d, out_b_q, out_b_d, out_c_q, out_c_d;
  logic                         busy_q, busy_d;

  logic             in_ready_c, accept_c, load_c, shift_c, produce_c;
  logic             emits_c, out_free_c, flush_go_c;
  logic [PIX_W-1:0] shift_in_c, tap_a_c, tap_b_c, tap_c_c;

  function automatic logic [PIX_W-1:0] mask_pix(input logic [PIX_W-1:0] p, input logic en);
    return en ? (p & ~LSB_MASK) : p;
  endfunction

  assign emits_c    = (s_q >= S_W'(S_OUT));
  assign out_free_c = !out_valid_q || bus.out_ready;

  // Ready only blocks when the coming shift would have to land in a full output register.
  always_comb begin
    in_ready_c = 1'b0;
    unique case (state_q)
      IDLE:         in_ready_c = 1'b1;
      FILL, STREAM: in_ready_c = emits_c ? out_free_c : 1'b1;
      FLUSH:        in_ready_c = 1'b0;
      default:      in_ready_c = 1'b0;
    endcase
    if (!reset_n) in_ready_c = 1'b0;
  end

  assign accept_c   = bus.in_valid && in_ready_c;
  assign load_c     = accept_c && (state_q == IDLE);
  assign flush_go_c = (state_q == FLUSH) && (!emits_c || out_free_c);
  assign shift_c    = (accept_c && (state_q != IDLE)) || flush_go_c;
  assign produce_c  = shift_c && emits_c;
  assign shift_in_c = flush_go_c ? win_q[TAPS-1] : mask_pix(bus.in_pix, approx_q);

  always_comb begin
    win_d = win_q;
    if (load_c)       win_d = {TAPS{mask_pix(bus.in_pix, bus.approx_en)}};
    else if (shift_c) win_d = {shift_in_c, win_q[TAPS-1:1]};
  end

  // Results are taken from the post-shift window so output n registers with p(n+4).
  subpel_taps #(.PIX_W(PIX_W)) u_taps (
    .win (win_d),
    .a_c (tap_a_c),
    .b_c (tap_b_c),
    .c_c (tap_c_c)
  );

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    f_d         = f_q;
    approx_d    = approx_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_c_d     = out_c_q;

    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;

    if (load_c) begin
      s_d      = '0;
      f_d      = '0;
      approx_d = bus.approx_en;
    end else if (shift_c && (s_q != S_W'(S_MAX))) begin
      s_d = s_q + S_W'(1);
    end

    if (flush_go_c) f_d = f_q + F_W'(1);

    if (produce_c) begin
      out_valid_d = 1'b1;
      out_last_d  = (state_q == FLUSH) && (f_q == F_W'(F_LAST));
      out_a_d     = tap_a_c;
      out_b_d     = tap_b_c;
      out_c_d     = tap_c_c;
    end

    unique case (state_q)
      IDLE:   if (accept_c) state_d = bus.in_last ? FLUSH : FILL;
      FILL:   if (accept_c) begin
                if (bus.in_last)              state_d = FLUSH;
                else if (s_d == S_W'(S_OUT))  state_d = STREAM;
              end
      STREAM: if (accept_c && bus.in_last) state_d = FLUSH;
      FLUSH:  if (flush_go_c && (f_q == F_W'(F_LAST))) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      win_q       <= '0;
      s_q         <= '0;
      f_q         <= '0;
      approx_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_c_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      s_q         <= s_d;
      f_q         <= f_d;
      approx_q    <= approx_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_c_q     <= out_c_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_a     = out_a_q;
  assign bus.out_b     = out_b_q;
  assign bus.out_c     = out_c_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_subpel_row_filter.sv
// Directed and randomized rows checked against a clamp-and-filter arithmetic reference.
module tb_subpel_row_filter;

  localparam int PIX_W      = 8;
  localparam int APPROX_LSB = 2;
  typedef logic [3*PIX_W:0] res_t;  // {last, a, b, c}

  logic clock = 1'b0;
  logic reset_n;
  logic busy;
  always #5 clock = ~clock;

  subpel_row_filter_if #(.PIX_W(PIX_W)) bus ();

  subpel_row_filter #(.PIX_W(PIX_W), .APPROX_LSB(APPROX_LSB)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus),
    .busy    (busy)
  );

  int   n_assert = 0;
  int   n_fail   = 0;
  bit   bp_mode  = 1'b0;
  res_t got_q[$];

  always @(posedge clock)
    if (reset_n && bus.out_valid && bus.out_ready)
      got_q.push_back({bus.out_last, bus.out_a, bus.out_b, bus.out_c});

  initial begin
    forever begin
      @(negedge clock);
      bus.out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rc(input int x);
    int y;
    y = (x + 32) >>> 6;
    if (y < 0) y = 0;
    if (y > 255) y = 255;
    return y;
  endfunction

  // Reference: replicate edges by clamping the index, mask, apply the three 8-tap filters.
  function automatic res_t model(input int row[$], input bit ax, input int n);
    int w[8];
    int nn, k, v, a, b, c;
    nn = row.size();
    for (int i = 0; i < 8; i++) begin
      k = n - 3 + i;
      if (k < 0) k = 0;
      if (k > nn - 1) k = nn - 1;
      v = row[k];
      if (ax) v = v & ~((1 << APPROX_LSB) - 1);
      w[i] = v;
    end
    a = -w[0] + 4*w[1] - 10*w[2] + 58*w[3] + 17*w[4] - 5*w[5] + w[6];
    b = -w[0] + 4*w[1] - 11*w[2] + 40*w[3] + 40*w[4] - 11*w[5] + 4*w[6] - w[7];
    c = w[1] - 5*w[2] + 17*w[3] + 58*w[4] - 10*w[5] + 4*w[6] - w[7];
    return {(n == nn - 1), PIX_W'(rc(a)), PIX_W'(rc(b)), PIX_W'(rc(c))};
  endfunction

  task automatic send_row(input string tag, input int row[$], input bit ax, input int toggle_at);
    bit rdy;
    int guard;
    for (int k = 0; k < row.size(); k++) begin
      @(negedge clock);
      bus.in_valid  = 1'b1;
      bus.in_pix    = PIX_W'(row[k]);
      bus.in_last   = (k == row.size() - 1);
      bus.approx_en = (toggle_at >= 0 && k >= toggle_at) ? ~ax : ax;
      guard = 0;
      forever begin
        #1;
        check({tag, "_in_ready"}, 64'(bus.in_ready),
              64'((k >= 4) ? (!bus.out_valid || bus.out_ready) : 1'b1));
        if (k == 2) check({tag, "_busy_mid"}, 64'(busy), 64'(1));
        rdy = bus.in_ready;
        @(posedge clock);
        if (rdy) break;
        guard++;
        if (guard > 100) begin
          check({tag, "_accept_timeout"}, 64'(0), 64'(1));
          break;
        end
        @(negedge clock);
      end
    end
    @(negedge clock);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic run_row(input string tag, input int row[$], input bit ax, input int toggle_at);
    int cyc;
    got_q.delete();
    send_row(tag, row, ax, toggle_at);
    cyc = 0;
    while (got_q.size() < row.size() && cyc < 300) begin
      @(negedge clock);
      cyc++;
    end
    @(negedge clock);
    check({tag, "_count"}, 64'(got_q.size()), 64'(row.size()));
    for (int n = 0; n < row.size() && n < got_q.size(); n++)
      check($sformatf("%s_out%0d", tag, n), 64'(got_q[n]), 64'(model(row, ax, n)));
    check({tag, "_busy_end"}, 64'(busy), 64'(0));
  endtask

  int row[$];
  res_t r;

  initial begin
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_pix    = '0;
    bus.in_last   = 1'b0;
    bus.approx_en = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clock);
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_in_ready", 64'(bus.in_ready), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_out_abc", 64'({bus.out_last, bus.out_a, bus.out_b, bus.out_c}), 64'(0));
    reset_n = 1'b1;
    #1 check("idle_in_ready", 64'(bus.in_ready), 64'(1));

    // Constant row
    row.delete();
    for (int i = 0; i < 16; i++) row.push_back(100);
    run_row("const", row, 1'b0, -1);
    check("const_last15", 64'(got_q[15]), 64'({1'b1, 8'd100, 8'd100, 8'd100}));

    // Step row with hand-derived values at the edge
    row.delete();
    for (int i = 0; i < 16; i++) row.push_back(i < 8 ? 0 : 255);
    run_row("step", row, 1'b0, -1);
    r = got_q[6]; check("step_a6", 64'(r[23:16]), 64'(0));
    r = got_q[7]; check("step_abc7", 64'(r[23:0]), 64'({8'd52, 8'd128, 8'd203}));
    r = got_q[8]; check("step_a8", 64'(r[23:16]), 64'(255));

    // Short rows
    row.delete(); row.push_back(77);
    run_row("n1", row, 1'b0, -1);
    check("n1_value", 64'(got_q[0]), 64'({1'b1, 8'd77, 8'd77, 8'd77}));
    row.delete(); row.push_back(10); row.push_back(200); row.push_back(30);
    run_row("n3", row, 1'b0, -1);

    // Approximate mode, then exact, then mid-row toggle
    row.delete();
    for (int i = 0; i < 16; i++) row.push_back(103);
    run_row("approx_on", row, 1'b1, -1);
    check("approx_on_val", 64'(got_q[5]), 64'({1'b0, 8'd100, 8'd100, 8'd100}));
    run_row("approx_off", row, 1'b0, -1);
    check("approx_off_val", 64'(got_q[5]), 64'({1'b0, 8'd103, 8'd103, 8'd103}));
    run_row("approx_tog1", row, 1'b1, 5);
    run_row("approx_tog0", row, 1'b0, 3);

    // Back-pressure on the step row
    bp_mode = 1'b1;
    row.delete();
    for (int i = 0; i < 16; i++) row.push_back(i < 8 ? 0 : 255);
    run_row("step_bp", row, 1'b0, -1);

    // Random rows under back-pressure
    for (int t = 0; t < 6; t++) begin
      bit ax;
      int len;
      row.delete();
      len = $urandom_range(1, 20);
      ax  = 1'($urandom_range(0, 1));
      for (int i = 0; i < len; i++) row.push_back($urandom_range(0, 255));
      run_row($sformatf("rand%0d", t), row, ax, -1);
    end
    bp_mode = 1'b0;

    // Reset in the middle of a row
    @(negedge clock);
    for (int k = 0; k < 6; k++) begin
      bus.in_valid  = 1'b1;
      bus.in_pix    = PIX_W'(50 + k * 20);
      bus.in_last   = 1'b0;
      bus.approx_en = 1'b0;
      @(negedge clock);
    end
    bus.in_valid = 1'b0;
    reset_n = 1'b0;
    #1 check("mid_rst_in_ready", 64'(bus.in_ready), 64'(0));
    @(negedge clock);
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_in_ready2", 64'(bus.in_ready), 64'(0));
    reset_n = 1'b1;
    #1 check("post_rst_in_ready", 64'(bus.in_ready), 64'(1));
    row.delete();
    for (int i = 0; i < 16; i++) row.push_back(100);
    run_row("post_rst", row, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
